// File: rtl/pdm_tx.sv
// pdm_tx: PCM sample FIFO feeding a second-order sigma-delta modulator that drives a 1-bit PDM stream.
// Define PDM_TX_DITHER_EN to add 2-bit LFSR dither to the modulator input.
module pdm_tx #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TICK_DIV   = 32,
    parameter int unsigned OSR        = 256
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         enable_in,
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    input  logic                         sample_valid_in,
    output logic                         sample_ready_out,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count_out,
    output logic                         tick_out,
    output logic                         sample_req_out,
    output logic                         underflow_out,
    output logic                         pdm_out
);

    localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned DIVW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned OSW  = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int unsigned W    = DATA_WIDTH + 4;
    localparam int unsigned SW   = W + 2;

    localparam logic signed [W-1:0] MAX_W  = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_W  = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] FB_POS = {{(W-DATA_WIDTH){1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [W-1:0] FB_NEG = {{(W-DATA_WIDTH){1'b1}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH-1:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                count_q, count_d;
    logic                         ready_q, ready_d;
    logic [DIVW-1:0]              div_cnt_q, div_cnt_d;
    logic [OSW-1:0]               os_cnt_q, os_cnt_d;
    logic signed [DATA_WIDTH-1:0] cur_q, cur_d;
    logic signed [W-1:0]          acc1_q, acc1_d, acc2_q, acc2_d;
    logic                         pdm_q, pdm_d;
    logic                         req_q, req_d, uf_q, uf_d;

    logic                         tick_c, pull_c, pop_c, push_c;
    logic signed [W-1:0]          x_c, fb_c, a1_c, a2_c;
    logic signed [SW-1:0]         s1_c, s2_c;

    function automatic logic signed [W-1:0] sat_w(input logic signed [SW-1:0] v);
        logic signed [W-1:0] r;
        r = W'(v);
        if (v > SW'(MAX_W)) r = MAX_W;
        if (v < SW'(MIN_W)) r = MIN_W;
        return r;
    endfunction

`ifdef PDM_TX_DITHER_EN
    logic [15:0]         lfsr_q, lfsr_d;
    logic signed [1:0]   dith_c;

    assign dith_c = lfsr_q[1:0];

    // Dither source: x^16+x^14+x^13+x^11+1, one step per PDM bit
    always_comb begin
        lfsr_d = lfsr_q;
        if (tick_c) lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) lfsr_q <= 16'hACE1;
        else         lfsr_q <= lfsr_d;
    end

    assign x_c = W'(cur_q) + W'(dith_c);
`else
    assign x_c = W'(cur_q);
`endif

    assign tick_c = enable_in && (div_cnt_q == DIVW'(TICK_DIV - 1));
    assign pull_c = tick_c && (os_cnt_q == OSW'(OSR - 1));
    assign pop_c  = pull_c && (count_q != '0);
    assign push_c = sample_valid_in && ready_q;

    assign fb_c = pdm_q ? FB_POS : FB_NEG;
    assign s1_c = SW'(acc1_q) + SW'(x_c) - SW'(fb_c);
    assign a1_c = sat_w(s1_c);
    assign s2_c = SW'(acc2_q) + SW'(a1_c) - SW'(fb_c);
    assign a2_c = sat_w(s2_c);

    // Next-state: FIFO bookkeeping, tick divider, sample pull and modulator
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q + CW'(push_c) - CW'(pop_c);
        ready_d   = 1'b0;
        div_cnt_d = '0;
        os_cnt_d  = '0;
        cur_d     = cur_q;
        acc1_d    = '0;
        acc2_d    = '0;
        pdm_d     = 1'b0;
        req_d     = pop_c;
        uf_d      = pull_c && (count_q == '0);

        ready_d = (count_d < CW'(FIFO_DEPTH));
        if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            cur_d    = DATA_WIDTH'(mem_q[rd_ptr_q]);
        end

        if (enable_in) begin
            acc1_d = acc1_q;
            acc2_d = acc2_q;
            pdm_d  = pdm_q;
            os_cnt_d = os_cnt_q;
            if (tick_c) begin
                div_cnt_d = '0;
                os_cnt_d  = (os_cnt_q == OSW'(OSR - 1)) ? '0 : os_cnt_q + OSW'(1);
                acc1_d    = a1_c;
                acc2_d    = a2_c;
                pdm_d     = ~a2_c[W-1];
            end else begin
                div_cnt_d = div_cnt_q + DIVW'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_c) mem_q[wr_ptr_q] <= sample_in;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ready_q   <= 1'b1;
            div_cnt_q <= '0;
            os_cnt_q  <= '0;
            cur_q     <= '0;
            acc1_q    <= '0;
            acc2_q    <= '0;
            pdm_q     <= 1'b0;
            req_q     <= 1'b0;
            uf_q      <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            div_cnt_q <= div_cnt_d;
            os_cnt_q  <= os_cnt_d;
            cur_q     <= cur_d;
            acc1_q    <= acc1_d;
            acc2_q    <= acc2_d;
            pdm_q     <= pdm_d;
            req_q     <= req_d;
            uf_q      <= uf_d;
        end
    end

    assign sample_ready_out = ready_q;
    assign fifo_count_out   = count_q;
    assign tick_out         = tick_c;
    assign sample_req_out   = req_q;
    assign underflow_out    = uf_q;
    assign pdm_out          = pdm_q;

endmodule
